// File: rtl/sobel_window_ctrl_if.sv
// Valid/ready byte stream used for both the pixel input and the edge-magnitude output.
// The master drives pixel/valid; the slave drives ready.
interface sobel_window_ctrl_if;
    logic [7:0] pixel;
    logic       valid;
    logic       ready;

    modport master (output pixel, output valid, input ready);
    modport slave  (input pixel, input valid, output ready);
endinterface

// File: rtl/sobel_window_ctrl.sv
// Frame sequencer for a 3x3 Sobel window: two line buffers, a tap window and a registered
// valid/ready output for the magnitude returned by the external sobel_core.
module sobel_window_ctrl #(
    parameter int MAX_WIDTH   = 640,
    parameter int WIDTH_BITS  = 10,
    parameter int HEIGHT_BITS = 10
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [WIDTH_BITS-1:0]  img_width_i,
    input  logic [HEIGHT_BITS-1:0] img_height_i,
    sobel_window_ctrl_if.slave     in_if,
    sobel_window_ctrl_if.master    out_if,
    output logic [7:0]             pix0_0_o,
    output logic [7:0]             pix0_1_o,
    output logic [7:0]             pix0_2_o,
    output logic [7:0]             pix1_0_o,
    output logic [7:0]             pix1_1_o,
    output logic [7:0]             pix1_2_o,
    output logic [7:0]             pix2_0_o,
    output logic [7:0]             pix2_1_o,
    output logic [7:0]             pix2_2_o,
    input  logic [7:0]             sobel_result_i,
    output logic                   busy_o,
    output logic                   frame_done_o
);
    localparam int ADDR_BITS = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam logic [WIDTH_BITS-1:0]  MAX_W = WIDTH_BITS'(MAX_WIDTH);
    localparam logic [WIDTH_BITS-1:0]  MIN_W = WIDTH_BITS'(3);
    localparam logic [HEIGHT_BITS-1:0] MIN_H = HEIGHT_BITS'(3);
    localparam logic [WIDTH_BITS-1:0]  COL2  = WIDTH_BITS'(2);
    localparam logic [HEIGHT_BITS-1:0] ROW1  = HEIGHT_BITS'(1);
    localparam logic [HEIGHT_BITS-1:0] ROW2  = HEIGHT_BITS'(2);

    typedef enum logic [1:0] {IDLE, PRIME, STREAM, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [WIDTH_BITS-1:0]  width_q, width_d, col_q, col_d;
    logic [HEIGHT_BITS-1:0] height_q, height_d, row_q, row_d;
    logic                   win_vld_q, win_vld_d;
    logic                   out_valid_q, out_valid_d;
    logic                   frame_done_q, frame_done_d;
    logic [7:0]             out_pixel_q, out_pixel_d;
    // Tap r*3+c: r=0 oldest row, c=0 oldest column.
    logic [8:0][7:0]        taps_q, taps_d;

    // Each entry packs {older row, newer row} for one column.
    logic [15:0]            lb_mem [MAX_WIDTH];
    logic [15:0]            lb_rd_q;

    logic start_ok, in_ready, accept, load, last_col;

    assign start_ok = start_i && (img_width_i >= MIN_W) && (img_width_i <= MAX_W)
                      && (img_height_i >= MIN_H);
    assign in_ready = ((state_q == PRIME) || (state_q == STREAM))
                      && (!win_vld_q || !out_valid_q || out_if.ready);
    assign accept   = in_if.valid && in_ready;
    assign load     = win_vld_q && (!out_valid_q || out_if.ready);
    assign last_col = (col_q == width_q - WIDTH_BITS'(1));

    always_comb begin
        state_d      = state_q;
        width_d      = width_q;
        height_d     = height_q;
        col_d        = col_q;
        row_d        = row_q;
        win_vld_d    = win_vld_q;
        out_valid_d  = out_valid_q;
        out_pixel_d  = out_pixel_q;
        frame_done_d = 1'b0;
        taps_d       = taps_q;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d  = PRIME;
                    width_d  = img_width_i;
                    height_d = img_height_i;
                    col_d    = '0;
                    row_d    = '0;
                end
            end
            PRIME: begin
                if (accept && (row_q == ROW1) && last_col) state_d = STREAM;
            end
            STREAM: begin
                if (accept && (row_q == height_q - HEIGHT_BITS'(1)) && last_col) state_d = DRAIN;
            end
            DRAIN: begin
                if (!win_vld_q && !out_valid_q) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = row_q + HEIGHT_BITS'(1);
            end else begin
                col_d = col_q + WIDTH_BITS'(1);
            end
            for (int r = 0; r < 3; r++) begin
                taps_d[r*3+0] = taps_q[r*3+1];
                taps_d[r*3+1] = taps_q[r*3+2];
            end
            taps_d[2] = lb_rd_q[15:8];
            taps_d[5] = lb_rd_q[7:0];
            taps_d[8] = in_if.pixel;
        end

        // Columns 0..1 would straddle the row wrap, so they never raise a window.
        if (accept && (row_q >= ROW2) && (col_q >= COL2)) begin
            win_vld_d = 1'b1;
        end else if (load) begin
            win_vld_d = 1'b0;
        end

        if (load) begin
            out_pixel_d = sobel_result_i;
            out_valid_d = 1'b1;
        end else if (out_if.ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            width_q      <= '0;
            height_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
            win_vld_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_pixel_q  <= '0;
            frame_done_q <= 1'b0;
            taps_q       <= '0;
        end else begin
            state_q      <= state_d;
            width_q      <= width_d;
            height_q     <= height_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_vld_q    <= win_vld_d;
            out_valid_q  <= out_valid_d;
            out_pixel_q  <= out_pixel_d;
            frame_done_q <= frame_done_d;
            taps_q       <= taps_d;
        end
    end

    // Read runs one pixel ahead at the next column, so the data is ready on the accept.
    always_ff @(posedge clk_i) begin
        if (accept) lb_mem[col_q[ADDR_BITS-1:0]] <= {lb_rd_q[7:0], in_if.pixel};
        lb_rd_q <= lb_mem[col_d[ADDR_BITS-1:0]];
    end

    assign in_if.ready  = in_ready;
    assign out_if.pixel = out_pixel_q;
    assign out_if.valid = out_valid_q;
    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = frame_done_q;

    assign pix0_0_o = taps_q[0];
    assign pix0_1_o = taps_q[1];
    assign pix0_2_o = taps_q[2];
    assign pix1_0_o = taps_q[3];
    assign pix1_1_o = taps_q[4];
    assign pix1_2_o = taps_q[5];
    assign pix2_0_o = taps_q[6];
    assign pix2_1_o = taps_q[7];
    assign pix2_2_o = taps_q[8];
endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Scoreboard bench: frames are stored as images, the expected magnitudes of every interior
// pixel are queued at issue, and a negedge monitor pops them on each output handshake.
module tb_sobel_window_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start;
    logic [9:0] w_in, h_in;
    logic [7:0] sres;
    logic [7:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;
    logic       busy, fdone;

    sobel_window_ctrl_if in_if ();
    sobel_window_ctrl_if out_if ();

    sobel_window_ctrl dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .img_width_i(w_in), .img_height_i(h_in),
        .in_if(in_if), .out_if(out_if),
        .pix0_0_o(p00), .pix0_1_o(p01), .pix0_2_o(p02),
        .pix1_0_o(p10), .pix1_1_o(p11), .pix1_2_o(p12),
        .pix2_0_o(p20), .pix2_1_o(p21), .pix2_2_o(p22),
        .sobel_result_i(sres), .busy_o(busy), .frame_done_o(fdone)
    );

    function automatic logic [7:0] sobel_mag(input int a, b, c, d, e, f, g, h, i);
        int gx, gy, m;
        gx = (c + 2*f + i) - (a + 2*d + g);
        gy = (g + 2*h + i) - (a + 2*b + c);
        m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy) + 0*e;
        return (m > 255) ? 8'd255 : m[7:0];
    endfunction

    // Stand-in for the external sobel_core.
    always_comb sres = sobel_mag(p00, p01, p02, p10, p11, p12, p20, p21, p22);

    int errors = 0, checks = 0;
    int cyc = 0;
    int img [16][32];
    int exp_q [$];
    int n_out = 0, spurious = 0, fdone_cnt = 0, first_out_cyc = -1, acc22_cyc = -1, last_out = -1;
    bit prev_hold = 0, saw_stall = 0;
    int prev_pix = 0;
    int rdy_mode = 0, stall_left = 0;
    bit stall_done = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rdy_mode != 2) stall_done = 0;
        if (rdy_mode == 2 && !stall_done && out_if.valid) begin
            stall_left = 5;
            stall_done = 1;
        end
        if (stall_left > 0) begin
            out_if.ready = 1'b0;
            stall_left--;
        end else if (rdy_mode == 1) begin
            out_if.ready = ($urandom_range(99) < 70);
        end else begin
            out_if.ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", int'(out_if.valid), 1);
                check("hold_pixel", int'(out_if.pixel), prev_pix);
            end
            if (out_if.valid && first_out_cyc < 0) first_out_cyc = cyc;
            if (out_if.valid && !out_if.ready && !in_if.ready) saw_stall = 1;
            if (out_if.valid && out_if.ready) begin
                n_out++;
                last_out = int'(out_if.pixel);
                if (exp_q.size() == 0) spurious++;
                else check("pixel", int'(out_if.pixel), exp_q.pop_front());
                $display("out #%0d pixel=%0d cyc=%0d", n_out, out_if.pixel, cyc);
            end
            prev_hold = out_if.valid && !out_if.ready;
            prev_pix  = int'(out_if.pixel);
            if (fdone) fdone_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int W, H, kind, v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (kind)
                    0:       img[r][c] = v;
                    1:       img[r][c] = (c >= 2) ? v : 0;
                    default: img[r][c] = $urandom_range(255);
                endcase
    endtask

    task automatic push_expected(input int W, H);
        for (int r = 1; r < H - 1; r++)
            for (int c = 1; c < W - 1; c++)
                exp_q.push_back(int'(sobel_mag(
                    img[r-1][c-1], img[r-1][c], img[r-1][c+1],
                    img[r][c-1],   img[r][c],   img[r][c+1],
                    img[r+1][c-1], img[r+1][c], img[r+1][c+1])));
    endtask

    task automatic pulse_start(input int W, H);
        w_in  = W[9:0];
        h_in  = H[9:0];
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_frame(input int W, H, gap, limit, input bit mid_start);
        int sent = 0;
        bit ok;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (sent == limit) begin
                    in_if.valid = 1'b0;
                    return;
                end
                while ($urandom_range(99) < gap) begin
                    in_if.valid = 1'b0;
                    tick();
                end
                if (mid_start && r == 1 && c == 0) begin
                    start = 1'b1;
                    w_in  = 10'd5;
                    h_in  = 10'd5;
                end
                in_if.valid = 1'b1;
                in_if.pixel = img[r][c][7:0];
                ok = 0;
                for (int t = 0; t < 200 && !ok; t++) begin
                    @(negedge clk);
                    ok = in_if.ready;
                    if (ok && r == 2 && c == 2) acc22_cyc = cyc;
                    tick();
                end
                start = 1'b0;
                if (!ok) begin
                    check("accept_timeout", int'(ok), 1);
                    in_if.valid = 1'b0;
                    return;
                end
                sent++;
            end
        end
        in_if.valid = 1'b0;
    endtask

    task automatic run_frame(input string nm, input int W, H, kind, v, gap, mode, input bit mid);
        int n0, t;
        rdy_mode = mode;
        fill(W, H, kind, v);
        push_expected(W, H);
        fdone_cnt = 0; spurious = 0; first_out_cyc = -1; acc22_cyc = -1;
        n0 = n_out;
        pulse_start(W, H);
        check({nm, "_busy"}, int'(busy), 1);
        send_frame(W, H, gap, -1, mid);
        t = 0;
        while (busy && t < 2000) begin
            tick();
            t++;
        end
        check({nm, "_frame_timeout"}, int'(busy), 0);
        repeat (3) tick();
        check({nm, "_frame_done_pulses"}, fdone_cnt, 1);
        check({nm, "_out_count"}, n_out - n0, (W - 2) * (H - 2));
        check({nm, "_leftover"}, exp_q.size(), 0);
        check({nm, "_spurious"}, spurious, 0);
        exp_q.delete();
        $display("frame %s W=%0d H=%0d outputs=%0d", nm, W, H, n_out - n0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; w_in = '0; h_in = '0;
        in_if.valid = 1'b0; in_if.pixel = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_in_ready", int'(in_if.ready), 0);
        check("rst_out_valid", int'(out_if.valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(fdone), 0);
        check("rst_out_pixel", int'(out_if.pixel), 0);
        check("rst_taps", int'(p00|p01|p02|p10|p11|p12|p20|p21|p22), 0);

        run_frame("const50", 4, 4, 0, 50, 0, 0, 0);
        check("const50_value", last_out, 0);
        run_frame("step10", 4, 4, 1, 10, 0, 0, 0);
        check("step10_value", last_out, 40);
        check("step10_latency", first_out_cyc - acc22_cyc, 2);
        run_frame("sat", 4, 4, 1, 100, 0, 0, 0);
        check("sat_value", last_out, 255);
        saw_stall = 0;
        run_frame("stall", 4, 4, 1, 10, 0, 2, 0);
        check("stall_value", last_out, 40);
        check("stall_in_ready_drop", int'(saw_stall), 1);

        pulse_start(2, 4);
        repeat (3) tick();
        check("w2_busy", int'(busy), 0);
        check("w2_in_ready", int'(in_if.ready), 0);
        pulse_start(641, 4);
        repeat (3) tick();
        check("w641_busy", int'(busy), 0);
        check("w641_in_ready", int'(in_if.ready), 0);
        pulse_start(5, 2);
        repeat (3) tick();
        check("h2_busy", int'(busy), 0);
        run_frame("midstart", 6, 5, 2, 0, 20, 1, 1);

        rdy_mode = 0;
        fill(4, 4, 2, 0);
        for (int c = 0; c < 4; c++) img[0][c] = 200;
        pulse_start(4, 4);
        send_frame(4, 4, 0, 7, 0);
        rst = 1'b1;
        tick();
        check("abort_in_ready", int'(in_if.ready), 0);
        check("abort_out_valid", int'(out_if.valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_out_pixel", int'(out_if.pixel), 0);
        check("abort_taps", int'(p00|p01|p02|p10|p11|p12|p20|p21|p22), 0);
        rst = 1'b0;
        tick();
        run_frame("w3h3", 3, 3, 1, 10, 0, 0, 0);
        check("w3h3_value", last_out, 40);

        for (int k = 0; k < 6; k++)
            run_frame("rand", 3 + $urandom_range(17), 3 + $urandom_range(9), 2, 0,
                      $urandom_range(40), 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
